dmem_sram_ctrl: RTL and testbench
=================================

// Module: dmem_sram_ctrl
// PURPOSE
//  Parametrised byte-addressable data memory for the pipeline MEM stage; next generation of the async-read SRAM.
//  Valid/ready request port, synchronous read with configurable latency, per-byte write enables.
//  Misaligned accesses are split into two internal word beats by a small FSM.
//  Little-endian: data byte i maps to byte address addr+i.
// PARAMETERS
//  DATA_W       32     access width in bits; multiple of 8, power of 2; NB = DATA_W/8 lanes
//  ADDR_W       16     byte-address width
//  DEPTH_BYTES  65536  storage size in bytes; power of 2, <= 2**ADDR_W, multiple of NB
//  RD_LAT       1      response latency in cycles for an aligned access, 1..4
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst        in   1       synchronous reset, active-high
//  req_valid  in   1       request present
//  req_ready  out  1       block can accept a request this cycle
//  req_we     in   1       1 = write, 0 = read
//  req_be     in   NB      byte enables for writes; ignored for reads
//  req_addr   in   ADDR_W  byte address, any alignment
//  req_wdata  in   DATA_W  write data, byte i -> addr+i
//  rsp_valid  out  1       one-cycle pulse, exactly one per accepted request
//  rsp_rdata  out  DATA_W  read data, byte i = mem[addr+i]; 0 for writes
//  rsp_err    out  1       error flag; exists only with DMEM_BOUNDS_CHECK_EN
// BEHAVIOUR
//  - Reset: FSM -> IDLE, pipeline valids cleared, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 next cycle.
//    Memory contents are not reset.
//  - Accept = req_valid & req_ready; request fields are captured on that edge.
//  - Offset o = req_addr mod NB; word W = addr/NB; W+1 wraps modulo DEPTH_BYTES/NB.
//  - Split condition:
//    read: o != 0.
//    write: any req_be[i]=1 with o+i >= NB.
//    Otherwise the access is single-beat.
//  - FSM states: IDLE, BEAT2.
//    IDLE: req_ready=1. Single-beat accept stays in IDLE. Split accept goes to BEAT2.
//    BEAT2: req_ready=0; goes to IDLE after 1 cycle.
//  - Beat 1 accesses word W, lanes o..NB-1, carrying data bytes 0..NB-1-o.
//    Beat 2 accesses word W+1, lanes 0..o-1, carrying bytes NB-o..NB-1.
//  - Writes commit at the beat edge, enabled lanes only.
//  - Array read is registered (stage 1), followed by RD_LAT-1 output stages. Reads of both beats are merged before output.
//  - Latency, accept edge to rsp_valid: RD_LAT cycles single-beat, RD_LAT+1 cycles split.
//  - Requests complete in order.
//  - Read-after-write: a read accepted after a write's final beat returns the new bytes.
//  - Write beat and read of the same word in one cycle cannot occur (one beat per cycle).
//  - Address wrap: addr+i is taken modulo DEPTH_BYTES; the top byte wraps to byte 0.
//  - Reset during BEAT2: beat 2 is dropped, any beat-1 write bytes stay, no response is issued.
//    Reset also kills all in-flight responses.
//  - req_be=0 on a write: no bytes change, response is still issued, single beat.
// CONFIGURATION
//  - DMEM_BOUNDS_CHECK_EN defined:
//    rsp_err port exists.
//    Any access with a byte address addr+i >= DEPTH_BYTES, checked before wrap, for any i in 0..NB-1 (all lanes, reads and writes), performs no array access.
//    It is forced single-beat, returns rsp_err=1 and rsp_rdata=0 after RD_LAT cycles.
//    rsp_err=0 on all other responses.
//  - Undefined: no rsp_err port; addresses wrap modulo DEPTH_BYTES as above.
// STRUCTURE
//  - dmem_pkg holds:
//    localparams NB and OFF_W=$clog2(NB);
//    typedef enum {IDLE, BEAT2} dmem_state_t;
//    function split_needed(we, be, off);
//    typedef of the response pipeline stage struct {valid, err, rdata}.
//  - Sub-module dmem_byte_rotator: combinational lane rotate by offset. Used for the write-data/be rotate and the read-data merge.
// TESTING
//  1. Reset, aligned write addr=0x10, be=1111, data=0xDEADBEEF; then read 0x10
//     -> rsp_rdata=0xDEADBEEF RD_LAT cycles after the read accept; rsp_valid high for 1 cycle per request.
//  2. Byte write addr=0x21, be=0010, data=0x0000AB00 over word 0x11223344 at 0x20
//     -> read 0x20 returns 0x11AB3344.
//  3. Misaligned write addr=0x33, be=1111, data=0x04030201
//     -> req_ready=0 for 1 cycle, rsp after RD_LAT+1.
//     -> read 0x33 returns 0x04030201; bytes 0x34..0x36 = 02,03,04.
//  4. Wrap (DEPTH_BYTES=65536): write addr=0xFFFE, data=0xCAFEBABE
//     -> mem[0xFFFE]=BE, [0xFFFF]=BA, [0x0000]=FE, [0x0001]=CA.
//     With DMEM_BOUNDS_CHECK_EN: the write instead returns rsp_err=1 and leaves memory unchanged.
//  5. Assert rst in the BEAT2 cycle of a split write
//     -> no rsp_valid; the beat-1 bytes are written, the beat-2 bytes unchanged; req_ready=1 after reset.
//  6. Back-to-back reads at 0x0, 0x4, 0x8 every cycle (RD_LAT=3)
//     -> three consecutive rsp_valid pulses, in order, starting 3 cycles after the first accept.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressable data memory controller.
// The default access width here sets NB/OFF_W for all dmem_* files.
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int NB          = DMEM_DATA_W / 8;
  localparam int OFF_W       = $clog2(NB);

  typedef enum logic [0:0] {
    IDLE,
    BEAT2
  } dmem_state_t;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [DMEM_DATA_W-1:0] rdata;
  } rsp_stage_t;

  // Misaligned reads always need the next word; writes only if an enabled byte spills over.
  function automatic logic split_needed(input logic we, input logic [NB-1:0] be,
                                        input logic [OFF_W-1:0] off);
    logic s;
    s = 1'b0;
    if (!we) begin
      s = (off != '0);
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (be[i] && (int'(off) + i >= NB)) s = 1'b1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/dmem_sram_ctrl_if.sv
// Request/response bus of the data memory; rsp_err exists only with DMEM_BOUNDS_CHECK_EN.
interface dmem_sram_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [NB-1:0]     req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic              rsp_err;

  modport master (output req_valid, req_we, req_be, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_be, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
`else
  modport master (output req_valid, req_we, req_be, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_be, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
`endif

endinterface

// File: rtl/dmem_byte_rotator.sv
// Combinational lane rotate by a lane offset; ROT_LEFT moves lane i to lane i+sh,
// otherwise lane i+sh moves to lane i (both modulo LANES).
module dmem_byte_rotator #(
  parameter int LANES    = 4,
  parameter int LANE_W   = 8,
  parameter bit ROT_LEFT = 1'b1,
  localparam int SH_W    = $clog2(LANES)
) (
  input  logic [LANES*LANE_W-1:0] din,
  input  logic [SH_W-1:0]         sh,
  output logic [LANES*LANE_W-1:0] dout
);

  logic [SH_W-1:0] src;

  always_comb begin
    dout = '0;
    src  = '0;
    for (int j = 0; j < LANES; j++) begin
      src = ROT_LEFT ? (SH_W'(j) - sh) : (SH_W'(j) + sh);
      dout[j*LANE_W +: LANE_W] = din[src*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/dmem_sram_ctrl.sv
// Byte-addressable data memory: valid/ready requests, RD_LAT-cycle responses (+1 when split),
// req_ready drops for the single BEAT2 cycle of a misaligned access. Option: DMEM_BOUNDS_CHECK_EN.
module dmem_sram_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_BYTES = 65536,
  parameter int RD_LAT      = 1
) (
  input  logic             clk,
  input  logic             rst,
  dmem_sram_ctrl_if.slave  bus
);

  localparam int WORDS = DEPTH_BYTES / NB;
  localparam int WA_W  = $clog2(WORDS);

  if (DATA_W != DMEM_DATA_W || RD_LAT < 1 || RD_LAT > 4) begin : g_param_err
    $error("dmem_sram_ctrl: unsupported DATA_W or RD_LAT");
  end

  dmem_state_t       state_q, state_d;
  logic              acc, split, oob;
  logic [OFF_W-1:0]  off;
  logic [WA_W-1:0]   word, word_nxt;
  logic [NB-1:0]     be_rot, hi_mask, b1_mask;
  logic [DATA_W-1:0] wdata_rot, rd_word, rd_word2, merged, merged_rot;

  logic [WA_W-1:0]   b2_word_q;
  logic              b2_we_q;
  logic [NB-1:0]     b2_mask_q;
  logic [DATA_W-1:0] b2_wdata_q, hold_q;
  logic [OFF_W-1:0]  b2_off_q;

  rsp_stage_t        s1_d;
  rsp_stage_t        pipe_q [RD_LAT];
  logic [DATA_W-1:0] mem [WORDS];

  assign off      = bus.req_addr[OFF_W-1:0];
  assign word     = bus.req_addr[OFF_W +: WA_W];
  assign word_nxt = word + WA_W'(1);
  assign acc      = bus.req_valid && (state_q == IDLE);
  assign rd_word  = mem[word];
  assign rd_word2 = mem[b2_word_q];

`ifdef DMEM_BOUNDS_CHECK_EN
  // Checked on the unwrapped address so the last lane's overflow is caught.
  assign oob = ({1'b0, bus.req_addr} + (ADDR_W+1)'(NB - 1)) >= (ADDR_W+1)'(DEPTH_BYTES);
`else
  assign oob = 1'b0;
`endif

  assign split = split_needed(bus.req_we, bus.req_be, off) && !oob;

  dmem_byte_rotator #(.LANES(NB), .LANE_W(8), .ROT_LEFT(1'b1)) u_rot_wdata (
    .din(bus.req_wdata), .sh(off), .dout(wdata_rot));

  dmem_byte_rotator #(.LANES(NB), .LANE_W(1), .ROT_LEFT(1'b1)) u_rot_be (
    .din(bus.req_be), .sh(off), .dout(be_rot));

  dmem_byte_rotator #(.LANES(NB), .LANE_W(8), .ROT_LEFT(1'b0)) u_rot_rd (
    .din(merged), .sh(b2_off_q), .dout(merged_rot));

  // Lanes at or above the offset belong to word W, the rest to word W+1.
  always_comb begin
    hi_mask = '0;
    merged  = '0;
    for (int j = 0; j < NB; j++) begin
      hi_mask[j] = (OFF_W'(j) >= off);
      merged[j*8 +: 8] = (OFF_W'(j) >= b2_off_q) ? hold_q[j*8 +: 8] : rd_word2[j*8 +: 8];
    end
  end

  assign b1_mask       = be_rot & hi_mask;
  assign bus.req_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid && split) state_d = BEAT2;
      BEAT2:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_d = '0;
    if (state_q == BEAT2) begin
      s1_d.valid = 1'b1;
      if (!b2_we_q) s1_d.rdata = merged_rot;
    end else if (acc && !split) begin
      s1_d.valid = 1'b1;
      s1_d.err   = oob;
      if (!bus.req_we && !oob) s1_d.rdata = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      pipe_q[0] <= s1_d;
      for (int k = 1; k < RD_LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (acc && split) begin
      b2_word_q  <= word_nxt;
      b2_we_q    <= bus.req_we;
      b2_mask_q  <= be_rot & ~hi_mask;
      b2_wdata_q <= wdata_rot;
      b2_off_q   <= off;
      hold_q     <= rd_word;
    end
  end

  // Reset blocks array writes, which is what drops a pending second beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (acc && bus.req_we && !oob) begin
        for (int j = 0; j < NB; j++)
          if (b1_mask[j]) mem[word][j*8 +: 8] <= wdata_rot[j*8 +: 8];
      end
      if (state_q == BEAT2 && b2_we_q) begin
        for (int j = 0; j < NB; j++)
          if (b2_mask_q[j]) mem[b2_word_q][j*8 +: 8] <= b2_wdata_q[j*8 +: 8];
      end
    end
  end

  assign bus.rsp_valid = pipe_q[RD_LAT-1].valid;
  assign bus.rsp_rdata = pipe_q[RD_LAT-1].rdata;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign bus.rsp_err   = pipe_q[RD_LAT-1].err;
`endif

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Directed bench for dmem_sram_ctrl with RD_LAT=3; works with or without DMEM_BOUNDS_CHECK_EN.
module tb_dmem_sram_ctrl;

  localparam int RD_LAT = 3;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dmem_sram_ctrl_if #(.DATA_W(32), .ADDR_W(16)) bus ();

  dmem_sram_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH_BYTES(65536), .RD_LAT(RD_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oob(input logic [15:0] a);
    return BC && (({1'b0, a} + 17'd3) > 17'h0FFFF);
  endfunction

  // One request, then watch ready and the response window cycle by cycle.
  task automatic xact(input string tag, input bit we, input logic [3:0] be,
                      input logic [15:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input bit split);
    bit          exp_err;
    bit          eff_split;
    logic [31:0] exp_data;
    int          lat;
    exp_err   = is_oob(addr);
    eff_split = split && !exp_err;
    exp_data  = (we || exp_err) ? 32'h0 : exp_rd;
    lat       = RD_LAT + (eff_split ? 1 : 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 0) check({tag, "/ready_after_accept"}, 32'(bus.req_ready), eff_split ? 32'd0 : 32'd1);
      if (k == 1 && eff_split) check({tag, "/ready_after_beat2"}, 32'(bus.req_ready), 32'd1);
      if (k == lat - 1) begin
        check({tag, "/rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "/rsp_rdata"}, bus.rsp_rdata, exp_data);
`ifdef DMEM_BOUNDS_CHECK_EN
        check({tag, "/rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
`endif
      end else begin
        check({tag, "/rsp_idle"}, 32'(bus.rsp_valid), 32'd0);
      end
    end
  endtask

  logic [31:0] exp6 [3];

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_be    = 4'h0;
    bus.req_addr  = 16'h0;
    bus.req_wdata = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst/rsp_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst/req_ready", 32'(bus.req_ready), 32'd1);

    // 1: aligned write then read
    xact("t1_wr", 1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("t1_rd", 1'b0, 4'h0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0);

    // Write with no byte enables: response only
    xact("be0_wr", 1'b1, 4'h0, 16'h0010, 32'h12345678, 32'h0, 1'b0);
    xact("be0_rd", 1'b0, 4'h0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0);

    // 2: single byte lane write at an unaligned address
    xact("t2_init", 1'b1, 4'hF, 16'h0020, 32'h11223344, 32'h0, 1'b0);
    xact("t2_wr",   1'b1, 4'b0010, 16'h0021, 32'h0000AB00, 32'h0, 1'b0);
    xact("t2_rd",   1'b0, 4'h0, 16'h0020, 32'h0, 32'h11AB3344, 1'b0);

    // 3: misaligned write split across two words
    xact("t3_init0", 1'b1, 4'hF, 16'h0030, 32'hAAAAAAAA, 32'h0, 1'b0);
    xact("t3_init1", 1'b1, 4'hF, 16'h0034, 32'h77665544, 32'h0, 1'b0);
    xact("t3_wr",    1'b1, 4'hF, 16'h0033, 32'h04030201, 32'h0, 1'b1);
    xact("t3_rd33",  1'b0, 4'h0, 16'h0033, 32'h0, 32'h04030201, 1'b1);
    xact("t3_rd34",  1'b0, 4'h0, 16'h0034, 32'h0, 32'h77040302, 1'b0);
    xact("t3_rd30",  1'b0, 4'h0, 16'h0030, 32'h0, 32'h01AAAAAA, 1'b0);

    // 4: top-of-memory wrap (rejected when bounds checking is built in)
    xact("t4_init0", 1'b1, 4'hF, 16'h0000, 32'h33221100, 32'h0, 1'b0);
    xact("t4_init1", 1'b1, 4'hF, 16'hFFFC, 32'h99887766, 32'h0, 1'b0);
    xact("t4_wr",    1'b1, 4'hF, 16'hFFFE, 32'hCAFEBABE, 32'h0, 1'b1);
    xact("t4_rd0",   1'b0, 4'h0, 16'h0000, 32'h0, BC ? 32'h33221100 : 32'h3322CAFE, 1'b0);
    xact("t4_rdFFFC", 1'b0, 4'h0, 16'hFFFC, 32'h0, BC ? 32'h99887766 : 32'hBABE7766, 1'b0);
    xact("t4_rdFFFE", 1'b0, 4'h0, 16'hFFFE, 32'h0, 32'hCAFEBABE, 1'b1);

    // 5: reset during BEAT2 of a split write
    xact("t5_init0", 1'b1, 4'hF, 16'h0040, 32'h44444444, 32'h0, 1'b0);
    xact("t5_init1", 1'b1, 4'hF, 16'h0044, 32'h55555555, 32'h0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_be    = 4'hF;
    bus.req_addr  = 16'h0042;
    bus.req_wdata = 32'h0D0C0B0A;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    check("t5/ready_in_beat2", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5/ready_after_rst", 32'(bus.req_ready), 32'd1);
    for (int k = 0; k < RD_LAT + 2; k++) begin
      check("t5/no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    xact("t5_rd40", 1'b0, 4'h0, 16'h0040, 32'h0, 32'h0B0A4444, 1'b0);
    xact("t5_rd44", 1'b0, 4'h0, 16'h0044, 32'h0, 32'h55555555, 1'b0);

    // 6: back-to-back reads, one per cycle
    xact("t6_init4", 1'b1, 4'hF, 16'h0004, 32'h13579BDF, 32'h0, 1'b0);
    xact("t6_init8", 1'b1, 4'hF, 16'h0008, 32'h2468ACE0, 32'h0, 1'b0);
    exp6[0] = BC ? 32'h33221100 : 32'h3322CAFE;
    exp6[1] = 32'h13579BDF;
    exp6[2] = 32'h2468ACE0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_be    = 4'h0;
    bus.req_addr  = 16'h0000;
    @(posedge clk);
    #1;
    check("t6/ready1", 32'(bus.req_ready), 32'd1);
    check("t6/idle0", 32'(bus.rsp_valid), 32'd0);
    bus.req_addr = 16'h0004;
    @(posedge clk);
    #1;
    check("t6/ready2", 32'(bus.req_ready), 32'd1);
    check("t6/idle1", 32'(bus.rsp_valid), 32'd0);
    bus.req_addr = 16'h0008;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        check("t6/rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t6/rsp_rdata", bus.rsp_rdata, exp6[k]);
      end else begin
        check("t6/rsp_end", 32'(bus.rsp_valid), 32'd0);
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
